// File: rtl/enemy_pkg.sv
// -----------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy sprite array: the per-channel state
// encoding, the transparent sprite colour, and the visible screen size.
// No ports.
// -----------------------------------------------------------------------------
package enemy_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        DEAD  = 2'd2
    } enemy_state_e;

    // Sprite pixels of this colour are see-through.
    localparam logic [11:0] TRANSPARENT_RGB = 12'h0F0;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/enemy_array_if.sv
// -----------------------------------------------------------------------------
// enemy_array_if
// Video-side bundle of the enemy array: scan coordinates in, sprite ROM
// address out, ROM data back in, and the resulting pixel out.
//
// Signals:
//   h_cnt, v_cnt  [9:0]        current scan position
//   rom_addr      [ADDR_W-1:0] sprite ROM address (ROM has 1-cycle latency)
//   rom_data      [11:0]       sprite ROM read data
//   pixel         [11:0]       RGB444 colour, 0 when no enemy owns the pixel
//   pixel_valid                an enemy owns this pixel
//
// Modports:
//   master  display / scan side (drives scan position and ROM data)
//   slave   enemy_array side
// -----------------------------------------------------------------------------
interface enemy_array_if #(
    parameter int ADDR_W = 15
);
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [11:0]       pixel;
    logic              pixel_valid;

    modport master (
        output h_cnt,
        output v_cnt,
        output rom_data,
        input  rom_addr,
        input  pixel,
        input  pixel_valid
    );

    modport slave (
        input  h_cnt,
        input  v_cnt,
        input  rom_data,
        output rom_addr,
        output pixel,
        output pixel_valid
    );
endinterface

// File: rtl/enemy_chan.sv
// -----------------------------------------------------------------------------
// enemy_chan
// One enemy channel: life-cycle FSM, flash (dying) timer, saturating kill
// counter, registered contact-damage flag and sprite window compare.
//
// Optional build macro: ENEMY_HIT_FLASH_EN -- when defined, the channel
// reports "blank" on alternate flash steps while dying so the sprite blinks.
//
// Ports:
//   clk, rst_n        clock and (already synchronised) active-low reset
//   tick              one-cycle game-step strobe
//   pos [POS_W-1:0]   lane position of this channel
//   hit               channel is being struck (level)
//   h_cnt, v_cnt      scan coordinates
//   active            channel is drawable (not DEAD)
//   in_win            scan position lies inside this channel's sprite window
//   local_addr        sprite-local ROM offset for the scan position
//   blank             suppress drawing this cycle (flash blink)
//   damage            registered player-contact damage flag
//   kill_cnt [7:0]    saturating kill counter
//
// state | meaning
// ------+-------------------------------------------------------------
// ALIVE | on screen, can be hit, deals damage on contact lanes
// DYING | struck, flashing for FLASH_TICKS ticks, ignores further hits
// DEAD  | off screen, waiting for a tick with pos==0 to respawn
// -----------------------------------------------------------------------------
module enemy_chan
    import enemy_pkg::*;
#(
    parameter int IDX         = 0,
    parameter int POS_W       = 5,
    parameter int LANE_END    = 10,
    parameter int SPR_W       = 160,
    parameter int SPR_H       = 120,
    parameter int ADDR_W      = 15,
    parameter int LANE_STEP   = 48,
    parameter int ROW_STEP    = 120,
    parameter int FLASH_TICKS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [POS_W-1:0]  pos,
    input  logic              hit,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    output logic              active,
    output logic              in_win,
    output logic [ADDR_W-1:0] local_addr,
    output logic              blank,
    output logic              damage,
    output logic [7:0]        kill_cnt
);

    localparam logic [1:0] S_ALIVE = 2'(ALIVE);
    localparam logic [1:0] S_DYING = 2'(DYING);
    localparam logic [1:0] S_DEAD  = 2'(DEAD);

    // Flash timer counts down from FLASH_TICKS-1; the tick seen at zero ends
    // the dying phase, so exactly FLASH_TICKS ticks are spent in DYING.
    localparam int             FC_W    = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLASH_TICKS - 1);

    logic [1:0]      state_q;
    logic [FC_W-1:0] flash_q;
    logic [7:0]      kill_q;
    logic            damage_q;
    logic            at_contact;

    assign at_contact = (pos == '0) || (pos == POS_W'(LANE_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ALIVE;
            flash_q  <= '0;
            kill_q   <= '0;
            damage_q <= 1'b0;
        end else begin
            // A hit in the same cycle as a contact lane suppresses damage.
            damage_q <= (state_q == S_ALIVE) && !hit && at_contact;

            case (state_q)
                S_ALIVE: begin
                    if (hit) begin
                        state_q <= S_DYING;
                        flash_q <= FC_LOAD;
                        if (kill_q != 8'hFF) begin
                            kill_q <= kill_q + 8'd1;
                        end
                    end
                end
                S_DYING: begin
                    if (tick) begin
                        if (flash_q == '0) begin
                            state_q <= S_DEAD;
                        end else begin
                            flash_q <= flash_q - 1'b1;
                        end
                    end
                end
                S_DEAD: begin
                    // Positions beyond LANE_END are off-screen; only lane 0 respawns.
                    if (tick && (pos == '0)) begin
                        state_q <= S_ALIVE;
                    end
                end
                default: begin
                    state_q <= S_ALIVE;
                end
            endcase
        end
    end

    assign active   = (state_q != S_DEAD);
    assign damage   = damage_q;
    assign kill_cnt = kill_q;

`ifdef ENEMY_HIT_FLASH_EN
    assign blank = (state_q == S_DYING) && flash_q[0];
`else
    assign blank = 1'b0;
`endif

    // Window compare in 11-bit unsigned arithmetic, clipped to the screen.
    logic [10:0] x0, x1, y0, y1, hx, vy, dx, dy;

    assign hx = {1'b0, h_cnt};
    assign vy = {1'b0, v_cnt};
    assign x0 = 11'(pos) * 11'(LANE_STEP);
    assign x1 = x0 + 11'(SPR_W);
    assign y0 = 11'(IDX * ROW_STEP);
    assign y1 = y0 + 11'(SPR_H);
    assign dx = hx - x0;
    assign dy = vy - y0;

    assign in_win = (hx >= x0) && (hx < x1) &&
                    (vy >= y0) && (vy < y1) &&
                    (hx < 11'(SCREEN_W)) && (vy < 11'(SCREEN_H));

    assign local_addr = ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W);

endmodule

// File: rtl/enemy_array.sv
// -----------------------------------------------------------------------------
// enemy_array
// NUM_ENEMY independent enemy channels sharing one sprite ROM. Each scan
// position is owned by the lowest-index drawable channel whose window
// contains it; that channel's local offset addresses the ROM and the
// ownership flag is delayed one cycle to line up with the ROM data.
//
// Optional build macro: ENEMY_HIT_FLASH_EN -- dying sprites blink (passed
// down to enemy_chan). Without it dying sprites are drawn steadily.
//
// Ports:
//   clk                         system clock
//   rst                         asynchronous active-low reset; assertion is
//                               immediate, release is synchronised (2 flops)
//   tick                        one-cycle game-step strobe
//   pos [NUM_ENEMY*POS_W-1:0]   packed lane positions, channel i at i*POS_W
//   hit [NUM_ENEMY-1:0]         per-channel strike level
//   vid                         enemy_array_if.slave: scan in, ROM, pixel out
//   damage [NUM_ENEMY-1:0]      registered per-channel contact damage
//   damage_any                  OR of damage
//   kill_cnt [NUM_ENEMY*8-1:0]  per-channel saturating kill counters
// -----------------------------------------------------------------------------
module enemy_array
    import enemy_pkg::*;
#(
    parameter int NUM_ENEMY   = 2,
    parameter int POS_W       = 5,
    parameter int LANE_END    = 10,
    parameter int SPR_W       = 160,
    parameter int SPR_H       = 120,
    parameter int ADDR_W      = 15,
    parameter int LANE_STEP   = 48,
    parameter int ROW_STEP    = 120,
    parameter int FLASH_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [NUM_ENEMY*POS_W-1:0] pos,
    input  logic [NUM_ENEMY-1:0]       hit,
    enemy_array_if.slave               vid,
    output logic [NUM_ENEMY-1:0]       damage,
    output logic                       damage_any,
    output logic [NUM_ENEMY*8-1:0]     kill_cnt
);

    // Reset: asserts asynchronously, releases two clk edges after rst rises.
    logic [1:0] rst_ff;
    logic       rst_n_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_ff <= 2'b00;
        end else begin
            rst_ff <= {rst_ff[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_ff[1];

    logic              chan_active [NUM_ENEMY];
    logic              chan_in_win [NUM_ENEMY];
    logic              chan_blank  [NUM_ENEMY];
    logic [ADDR_W-1:0] chan_addr   [NUM_ENEMY];

    for (genvar i = 0; i < NUM_ENEMY; i++) begin : g_chan
        enemy_chan #(
            .IDX         (i),
            .POS_W       (POS_W),
            .LANE_END    (LANE_END),
            .SPR_W       (SPR_W),
            .SPR_H       (SPR_H),
            .ADDR_W      (ADDR_W),
            .LANE_STEP   (LANE_STEP),
            .ROW_STEP    (ROW_STEP),
            .FLASH_TICKS (FLASH_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n_sync),
            .tick       (tick),
            .pos        (pos[i*POS_W +: POS_W]),
            .hit        (hit[i]),
            .h_cnt      (vid.h_cnt),
            .v_cnt      (vid.v_cnt),
            .active     (chan_active[i]),
            .in_win     (chan_in_win[i]),
            .local_addr (chan_addr[i]),
            .blank      (chan_blank[i]),
            .damage     (damage[i]),
            .kill_cnt   (kill_cnt[i*8 +: 8])
        );
    end

    assign damage_any = |damage;

    // Walk from the highest index down so the lowest-index owner wins.
    logic              owner_hit;
    logic              owner_blank;
    logic [ADDR_W-1:0] owner_addr;

    always_comb begin
        owner_hit   = 1'b0;
        owner_blank = 1'b0;
        owner_addr  = '0;
        for (int i = NUM_ENEMY - 1; i >= 0; i--) begin
            if (chan_in_win[i] && chan_active[i]) begin
                owner_hit   = 1'b1;
                owner_blank = chan_blank[i];
                owner_addr  = chan_addr[i];
            end
        end
    end

    assign vid.rom_addr = owner_addr;

    // Ownership is delayed to meet the ROM's read data.
    logic owner_valid_q;
    logic owner_blank_q;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            owner_valid_q <= 1'b0;
            owner_blank_q <= 1'b0;
        end else begin
            owner_valid_q <= owner_hit;
            owner_blank_q <= owner_blank;
        end
    end

    logic pix_ok;

    assign pix_ok          = owner_valid_q && !owner_blank_q &&
                             (vid.rom_data != TRANSPARENT_RGB);
    assign vid.pixel_valid = pix_ok;
    assign vid.pixel       = pix_ok ? vid.rom_data : 12'h000;

endmodule

// File: tb/tb_enemy_array.sv
// -----------------------------------------------------------------------------
// tb_enemy_array
// Directed self-checking bench for enemy_array. The DUT uses ROW_STEP=40 so
// the two channel rows overlap vertically and ownership priority can be seen.
// -----------------------------------------------------------------------------
module tb_enemy_array;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [9:0]  pos;
    logic [1:0]  hit;
    logic [1:0]  damage;
    logic        damage_any;
    logic [15:0] kill_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    enemy_array_if #(.ADDR_W(15)) vid ();

    enemy_array #(
        .NUM_ENEMY   (2),
        .POS_W       (5),
        .LANE_END    (10),
        .SPR_W       (160),
        .SPR_H       (120),
        .ADDR_W      (15),
        .LANE_STEP   (48),
        .ROW_STEP    (40),
        .FLASH_TICKS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .pos        (pos),
        .hit        (hit),
        .vid        (vid),
        .damage     (damage),
        .damage_any (damage_any),
        .kill_cnt   (kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [4:0] p1, input logic [4:0] p0);
        pos = {p1, p0};
    endtask

    task automatic test_reset();
        rst = 1'b0; tick = 1'b0; hit = 2'b00;
        set_pos(5'd5, 5'd3);
        vid.h_cnt = 10'd600; vid.v_cnt = 10'd300; vid.rom_data = 12'h000;
        cyc(); cyc();
        n_tests++; if (damage !== 2'b00) begin n_fail++; $display("FAIL reset_damage: got %b expected 00", damage); end
        n_tests++; if (damage_any !== 1'b0) begin n_fail++; $display("FAIL reset_damage_any: got %b expected 0", damage_any); end
        n_tests++; if (kill_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_kill: got %h expected 0000", kill_cnt); end
        n_tests++; if (vid.pixel_valid !== 1'b0 || vid.pixel !== 12'h000) begin
            n_fail++; $display("FAIL reset_pixel: got valid=%b pixel=%h expected 0/000", vid.pixel_valid, vid.pixel); end
        n_tests++; if (vid.rom_addr !== 15'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", vid.rom_addr); end
        rst = 1'b1;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_damage();
        set_pos(5'd5, 5'd0);
        cyc();
        n_tests++; if (damage !== 2'b01) begin n_fail++; $display("FAIL damage_lane0: got %b expected 01", damage); end
        n_tests++; if (damage_any !== 1'b1) begin n_fail++; $display("FAIL damage_any_lane0: got %b expected 1", damage_any); end
        set_pos(5'd10, 5'd3);
        cyc();
        n_tests++; if (damage !== 2'b10) begin n_fail++; $display("FAIL damage_lane_end: got %b expected 10", damage); end
        set_pos(5'd5, 5'd3);
        cyc();
        n_tests++; if (damage !== 2'b00 || damage_any !== 1'b0) begin
            n_fail++; $display("FAIL damage_clear: got %b/%b expected 00/0", damage, damage_any); end
    endtask

    task automatic test_hit_contact();
        set_pos(5'd5, 5'd10);
        hit = 2'b01;
        cyc();
        n_tests++; if (damage[0] !== 1'b0) begin n_fail++; $display("FAIL hit_wins_damage: got %b expected 0", damage[0]); end
        n_tests++; if (kill_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL hit_kill: got %0d expected 1", kill_cnt[7:0]); end
        cyc();
        n_tests++; if (kill_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL hit_held_kill: got %0d expected 1", kill_cnt[7:0]); end
        hit = 2'b00;
        cyc();
        n_tests++; if (damage !== 2'b00) begin n_fail++; $display("FAIL dying_no_damage: got %b expected 00", damage); end
    endtask

    task automatic test_dying();
        logic exp_valid;
        vid.h_cnt = 10'd500; vid.v_cnt = 10'd10; vid.rom_data = 12'h123;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd1620) begin n_fail++; $display("FAIL dying_addr: got %0d expected 1620", vid.rom_addr); end
        cyc();
`ifdef ENEMY_HIT_FLASH_EN
        exp_valid = 1'b0;
`else
        exp_valid = 1'b1;
`endif
        n_tests++; if (vid.pixel_valid !== exp_valid) begin
            n_fail++; $display("FAIL dying_draw: got %b expected %b", vid.pixel_valid, exp_valid); end
        for (int i = 0; i < 7; i++) begin
            tick = 1'b1;
            hit  = (i == 3) ? 2'b01 : 2'b00;
            cyc();
            tick = 1'b0;
            hit  = 2'b00;
        end
        #1;
        n_tests++; if (vid.rom_addr !== 15'd1620) begin n_fail++; $display("FAIL dying_7ticks: got %0d expected 1620", vid.rom_addr); end
        n_tests++; if (kill_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL dying_hit_ignored: got %0d expected 1", kill_cnt[7:0]); end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd0) begin n_fail++; $display("FAIL dead_8th_tick: got %0d expected 0", vid.rom_addr); end
        cyc();
        n_tests++; if (vid.pixel_valid !== 1'b0) begin n_fail++; $display("FAIL dead_pixel: got %b expected 0", vid.pixel_valid); end
        set_pos(5'd5, 5'd12);
        vid.h_cnt = 10'd600;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd0) begin n_fail++; $display("FAIL offscreen_no_spawn: got %0d expected 0", vid.rom_addr); end
        set_pos(5'd5, 5'd0);
        vid.h_cnt = 10'd10;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd1610) begin n_fail++; $display("FAIL respawn_addr: got %0d expected 1610", vid.rom_addr); end
        cyc();
        n_tests++; if (damage !== 2'b01) begin n_fail++; $display("FAIL respawn_damage: got %b expected 01", damage); end
        set_pos(5'd5, 5'd3);
        cyc();
    endtask

    task automatic test_priority();
        set_pos(5'd1, 5'd2);
        vid.h_cnt = 10'd100; vid.v_cnt = 10'd60; vid.rom_data = 12'h000;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd9604) begin n_fail++; $display("FAIL overlap_addr: got %0d expected 9604", vid.rom_addr); end
        cyc();
        vid.rom_data = 12'hABC;
        vid.h_cnt = 10'd50;
        #1;
        n_tests++; if (vid.pixel !== 12'hABC || vid.pixel_valid !== 1'b1) begin
            n_fail++; $display("FAIL overlap_pixel: got %h/%b expected ABC/1", vid.pixel, vid.pixel_valid); end
        n_tests++; if (vid.rom_addr !== 15'd3202) begin n_fail++; $display("FAIL ch1_addr: got %0d expected 3202", vid.rom_addr); end
        cyc();
        vid.rom_data = 12'h0F0;
        vid.h_cnt = 10'd600; vid.v_cnt = 10'd300;
        #1;
        n_tests++; if (vid.pixel_valid !== 1'b0 || vid.pixel !== 12'h000) begin
            n_fail++; $display("FAIL transparent: got %h/%b expected 000/0", vid.pixel, vid.pixel_valid); end
        n_tests++; if (vid.rom_addr !== 15'd0) begin n_fail++; $display("FAIL no_owner_addr: got %0d expected 0", vid.rom_addr); end
        cyc();
        vid.rom_data = 12'hABC;
        #1;
        n_tests++; if (vid.pixel_valid !== 1'b0 || vid.pixel !== 12'h000) begin
            n_fail++; $display("FAIL no_owner_pixel: got %h/%b expected 000/0", vid.pixel, vid.pixel_valid); end
        set_pos(5'd1, 5'd12);
        vid.h_cnt = 10'd700; vid.v_cnt = 10'd10;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd0) begin n_fail++; $display("FAIL clip_640: got %0d expected 0", vid.rom_addr); end
        vid.h_cnt = 10'd620;
        #1;
        n_tests++; if (vid.rom_addr !== 15'd1644) begin n_fail++; $display("FAIL clip_inside: got %0d expected 1644", vid.rom_addr); end
        set_pos(5'd5, 5'd3);
        cyc();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            hit = 2'b10;
            cyc();
            hit = 2'b00;
            if (i == 254 || i == 255) begin
                n_tests++; if (kill_cnt[15:8] !== 8'd255) begin
                    n_fail++; $display("FAIL kill_sat_%0d: got %0d expected 255", i, kill_cnt[15:8]); end
            end
            for (int t = 0; t < 8; t++) begin
                tick = 1'b1;
                cyc();
            end
            tick = 1'b0;
            set_pos(5'd0, 5'd3);
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            set_pos(5'd5, 5'd3);
        end
        n_tests++; if (kill_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL kill_ch0_isolated: got %0d expected 1", kill_cnt[7:0]); end
    endtask

    task automatic test_reset_mid_dying();
        set_pos(5'd5, 5'd0);
        vid.h_cnt = 10'd10; vid.v_cnt = 10'd10; vid.rom_data = 12'hABC;
        hit = 2'b10;
        cyc();
        hit = 2'b00;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_tests++; if (vid.pixel_valid !== 1'b1 || damage !== 2'b01) begin
            n_fail++; $display("FAIL pre_reset: got valid=%b damage=%b expected 1/01", vid.pixel_valid, damage); end
        rst = 1'b0;
        #1;
        n_tests++; if (damage !== 2'b00 || damage_any !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_damage: got %b/%b expected 00/0", damage, damage_any); end
        n_tests++; if (kill_cnt !== 16'h0000) begin n_fail++; $display("FAIL async_reset_kill: got %h expected 0000", kill_cnt); end
        n_tests++; if (vid.pixel_valid !== 1'b0 || vid.pixel !== 12'h000) begin
            n_fail++; $display("FAIL async_reset_pixel: got %h/%b expected 000/0", vid.pixel, vid.pixel_valid); end
        set_pos(5'd5, 5'd3);
        cyc();
        rst = 1'b1;
        hit = 2'b10;
        cyc();
        n_tests++; if (kill_cnt[15:8] !== 8'd0) begin n_fail++; $display("FAIL release_edge1: got %0d expected 0", kill_cnt[15:8]); end
        cyc();
        n_tests++; if (kill_cnt[15:8] !== 8'd0) begin n_fail++; $display("FAIL release_edge2: got %0d expected 0", kill_cnt[15:8]); end
        cyc();
        n_tests++; if (kill_cnt[15:8] !== 8'd1) begin n_fail++; $display("FAIL release_edge3: got %0d expected 1", kill_cnt[15:8]); end
        hit = 2'b00;
        cyc();
    endtask

    initial begin
        test_reset();
        test_damage();
        test_hit_contact();
        test_dying();
        test_priority();
        test_saturation();
        test_reset_mid_dying();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_array.md
ENEMY_ARRAY -- requirements
Module: enemy_array

Interface
REQ-001 Parameter NUM_ENEMY, default 2, number of independent enemy channels (1..8).
REQ-002 Parameter POS_W, default 5, width of one lane-position field.
REQ-003 Parameter LANE_END, default 10, last lane position; positions 0 and LANE_END are the player-contact lanes.
REQ-004 Parameter SPR_W / SPR_H, default 160 / 120, sprite size in pixels; ADDR_W, default 15, ROM address width.
REQ-005 Parameter LANE_STEP / ROW_STEP, default 48 / 120, horizontal pitch per lane and vertical pitch per channel.
REQ-006 Parameter FLASH_TICKS, default 8, length of the dying phase in tick strobes.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 tick  input  1  one-cycle game-step strobe in the clk domain.
REQ-010 h_cnt, v_cnt  input  10 each  current VGA scan coordinates.
REQ-011 pos  input  NUM_ENEMY*POS_W  packed lane positions; channel i is in bits [i*POS_W +: POS_W].
REQ-012 hit  input  NUM_ENEMY  per-channel level, high while the channel is being struck.
REQ-013 rom_addr  output  ADDR_W  sprite ROM address; the ROM is synchronous with 1-cycle read latency.
REQ-014 rom_data  input  12  sprite ROM read data.
REQ-015 pixel / pixel_valid  output  12 / 1  RGB444 colour and the flag that an enemy owns this pixel.
REQ-016 damage  output  NUM_ENEMY  registered per-channel damage flags; damage_any  output  1  OR of damage.
REQ-017 kill_cnt  output  NUM_ENEMY*8  per-channel kill counters.

Function
REQ-018 Each channel runs a state machine ALIVE -> DYING -> DEAD -> ALIVE.
REQ-019 ALIVE -> DYING on the first cycle hit[i]=1; in that same cycle kill_cnt[i] increments, saturating at 255.
REQ-020 DYING counts tick strobes and moves to DEAD on the FLASH_TICKS-th tick; hit is ignored while DYING.
REQ-021 DEAD -> ALIVE on a cycle with tick=1 and pos[i]=0 (respawn); pos[i]>LANE_END is treated as off-screen and never spawns.
REQ-022 damage[i] next-state = 1 iff state ALIVE, hit[i]=0, and pos[i] is 0 or LANE_END; it is registered with 1-cycle latency.
REQ-023 When hit and a contact lane coincide in the same cycle, hit wins: damage=0 and the channel enters DYING.
REQ-024 Channel i window: x in [pos*LANE_STEP, pos*LANE_STEP+SPR_W), y in [i*ROW_STEP, i*ROW_STEP+SPR_H); arithmetic is 11-bit unsigned, and the window is clipped at 640x480.
REQ-025 Owner = lowest-index channel whose window contains (h_cnt,v_cnt) and whose state is not DEAD.
REQ-026 rom_addr = (x-x0) + (y-y0)*SPR_W of the owner, computed combinationally; it is 0 with no owner.
REQ-027 The owner-valid flag is registered one cycle to align with rom_data; pixel = rom_data when valid, else 12'h000.
REQ-028 pixel/pixel_valid latency is exactly 1 clk after h_cnt/v_cnt.
REQ-029 A rom_data value of 12'h0F0 is transparent: it forces pixel_valid=0 and pixel=0.

Reset
REQ-030 While rst=0: all channels ALIVE, flash counters 0, damage=0, damage_any=0, kill_cnt=0, pixel=0, pixel_valid=0.
REQ-031 Reset asserted mid-DYING aborts the flash and takes effect without a clk edge; release is synchronised by a 2-flop deassertion stage.

Configuration
REQ-032 Macro ENEMY_HIT_FLASH_EN: when defined, a DYING channel's pixel_valid is forced to 0 when flash counter bit0=1, making the sprite blink.
REQ-033 Without ENEMY_HIT_FLASH_EN, a DYING sprite is drawn steadily; the FSM timing is identical.

Structure
REQ-034 Shared package enemy_pkg holds the state enum (ALIVE, DYING, DEAD), the transparent colour constant, and the screen width and height constants.
REQ-035 One sub-module, enemy_chan, holds the per-channel FSM, flash counter, kill counter, damage register and window compare; it is instantiated NUM_ENEMY times by generate.

Verification
REQ-036 pos0=0, hit0=0 for 1 cycle -> damage[0]=1 on the next cycle and damage_any=1.
REQ-037 pos0=10, hit0=1 in the same cycle -> damage[0] stays 0, state goes DYING, kill_cnt[0]=1.
REQ-038 Hit, then 8 ticks, then tick with pos0=0 -> DYING, then DEAD at the 8th tick, then ALIVE; hit pulses while DYING leave kill_cnt unchanged.
REQ-039 Channels 0 and 1 windows overlap at (100,60), rom_data=12'hABC -> pixel=ABC one cycle later with channel 0 addressed (rom_addr = local offset of channel 0).
REQ-040 256 hit/respawn cycles on channel 1 -> kill_cnt[1] saturates at 255; rst=0 mid-DYING -> all outputs 0 immediately.
